// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the serial operand path: transmitter FSM states
// and the per-pair bit-order encoding carried alongside each operand pair.
package serial_cmp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic ORDER_LSB_FIRST = 1'b0;
    localparam logic ORDER_MSB_FIRST = 1'b1;

endpackage

// File: rtl/operand_holding_slot.sv
// One-entry buffer for an operand pair and its bit order. Upstream sees a
// registered ready that is low whenever the entry is occupied, so an accept
// can never land on an entry that is being drained on the same edge.
module operand_holding_slot #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_msb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_msb_first
);

    logic full;
    logic full_next;
    logic accept;
    logic drain;

    assign accept    = in_valid & in_ready;
    assign drain     = full & out_ready;
    assign out_valid = full;

    // Occupancy update: in_ready is low while full, so accept and drain are exclusive.
    always_comb begin
        full_next = full;
        if (drain) begin
            full_next = 1'b0;
        end else if (accept) begin
            full_next = 1'b1;
        end
    end

    // Occupancy, registered ready, and operand storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full          <= 1'b0;
            in_ready      <= 1'b0;
            out_a         <= '0;
            out_b         <= '0;
            out_msb_first <= 1'b0;
        end else begin
            full     <= full_next;
            in_ready <= !full_next;
            if (accept) begin
                out_a         <= in_a;
                out_b         <= in_b;
                out_msb_first <= in_msb_first;
            end
        end
    end

endmodule

// File: rtl/serial_operand_transmitter.sv
// Serialises operand pairs A/B one bit per transfer, in MSB-first or
// LSB-first order chosen per pair, with first/last word markers for a
// downstream bit-serial comparator. All serial outputs are registered.
module serial_operand_transmitter
    import serial_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_msb_first,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t            state;
    state_t            state_next;

    logic              slot_valid;
    logic              slot_take;
    logic [WIDTH-1:0]  slot_a;
    logic [WIDTH-1:0]  slot_b;
    logic              slot_msb;

    logic [WIDTH-1:0]  sh_a;
    logic [WIDTH-1:0]  sh_b;
    logic              msb;
    logic [CW-1:0]     cnt;

    logic [WIDTH-1:0]  sh_a_next;
    logic [WIDTH-1:0]  sh_b_next;
    logic              msb_next;
    logic [CW-1:0]     cnt_next;
    logic [CW-1:0]     cnt_inc;
    logic              valid_next;
    logic              a_next;
    logic              b_next;
    logic              first_next;
    logic              last_next;

    logic              xfer;
    logic              load;
    logic              advance;
    logic              finish;

    operand_holding_slot #(
        .WIDTH(WIDTH)
    ) u_slot (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_msb_first (in_msb_first),
        .out_valid    (slot_valid),
        .out_ready    (slot_take),
        .out_a        (slot_a),
        .out_b        (slot_b),
        .out_msb_first(slot_msb)
    );

    assign xfer      = ser_valid & ser_ready;
    assign cnt_inc   = cnt + CW'(1);
    assign slot_take = load;
    assign busy      = slot_valid | (state == SHIFT);

    // Next-state and next-output logic. The shifter keeps the bit currently
    // presented at its emitting end (top for MSB-first, bottom for LSB-first),
    // so the following bit is always one position in and can be registered.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        sh_a_next  = sh_a;
        sh_b_next  = sh_b;
        msb_next   = msb;
        cnt_next   = cnt;
        valid_next = ser_valid;
        a_next     = ser_a;
        b_next     = ser_b;
        first_next = ser_first;
        last_next  = ser_last;

        case (state)
            IDLE: begin
                load = slot_valid;
            end
            SHIFT: begin
                if (xfer) begin
                    if (ser_last) begin
                        load   = slot_valid;
                        finish = !slot_valid;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load) begin
            state_next = SHIFT;
            sh_a_next  = slot_a;
            sh_b_next  = slot_b;
            msb_next   = slot_msb;
            cnt_next   = '0;
            valid_next = 1'b1;
            a_next     = (slot_msb == ORDER_MSB_FIRST) ? slot_a[WIDTH-1] : slot_a[0];
            b_next     = (slot_msb == ORDER_MSB_FIRST) ? slot_b[WIDTH-1] : slot_b[0];
            first_next = 1'b1;
            last_next  = 1'b0;
        end else if (advance) begin
            cnt_next   = cnt_inc;
            first_next = 1'b0;
            last_next  = (cnt_inc == CW'(WIDTH - 1));
            if (msb == ORDER_MSB_FIRST) begin
                sh_a_next = sh_a << 1;
                sh_b_next = sh_b << 1;
                a_next    = sh_a[WIDTH-2];
                b_next    = sh_b[WIDTH-2];
            end else begin
                sh_a_next = sh_a >> 1;
                sh_b_next = sh_b >> 1;
                a_next    = sh_a[1];
                b_next    = sh_b[1];
            end
        end else if (finish) begin
            state_next = IDLE;
            cnt_next   = '0;
            valid_next = 1'b0;
            a_next     = 1'b0;
            b_next     = 1'b0;
            first_next = 1'b0;
            last_next  = 1'b0;
        end
    end

    // State, shifter and registered serial outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sh_a      <= '0;
            sh_b      <= '0;
            msb       <= ORDER_LSB_FIRST;
            cnt       <= '0;
            ser_valid <= 1'b0;
            ser_a     <= 1'b0;
            ser_b     <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            state     <= state_next;
            sh_a      <= sh_a_next;
            sh_b      <= sh_b_next;
            msb       <= msb_next;
            cnt       <= cnt_next;
            ser_valid <= valid_next;
            ser_a     <= a_next;
            ser_b     <= b_next;
            ser_first <= first_next;
            ser_last  <= last_next;
        end
    end

endmodule

// File: tb/tb_serial_operand_transmitter.sv
// Bench for serial_operand_transmitter: a per-cycle monitor compares the DUT
// against a queue of expected bits built from each accepted pair, and the
// directed tests pin recovered streams against hand-written literals.
module tb_serial_operand_transmitter;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_msb_first = 1'b0;
    logic         ser_valid;
    logic         ser_ready = 1'b0;
    logic         ser_a;
    logic         ser_b;
    logic         ser_first;
    logic         ser_last;
    logic         busy;

    int errors = 0;
    int checks = 0;

    serial_operand_transmitter #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_msb_first(in_msb_first),
        .ser_valid   (ser_valid),
        .ser_ready   (ser_ready),
        .ser_a       (ser_a),
        .ser_b       (ser_b),
        .ser_first   (ser_first),
        .ser_last    (ser_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    logic [3:0] expq[$];   // {a, b, first, last} still owed by the DUT
    logic [3:0] rec[$];    // every transferred bit, in order
    int         accepted = 0;
    int         begun = 0;
    int         completed = 0;
    int         edges = 0;
    logic       prev_stall = 1'b0;
    logic [4:0] prev_out = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_outputs", {in_ready, busy, ser_valid, ser_a, ser_b, ser_first, ser_last}, '0);
            expq.delete();
            accepted   = 0;
            begun      = 0;
            completed  = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {ser_valid, ser_a, ser_b, ser_first, ser_last}, prev_out);
            if (!ser_valid)
                chk("idle_zero", {ser_a, ser_b, ser_first, ser_last}, '0);
            if (ser_valid && ser_first && !prev_stall) begun++;
            chk("in_ready", in_ready, (edges > 0) && (accepted == begun));
            chk("busy", busy, accepted != completed);
            if (ser_valid && ser_ready) begin
                rec.push_back({ser_a, ser_b, ser_first, ser_last});
                if (expq.size() == 0) chk("unexpected_bit", 1, 0);
                else chk("bit", {ser_a, ser_b, ser_first, ser_last}, expq.pop_front());
                if (ser_last) completed++;
            end
            if (in_valid && in_ready) begin
                accepted++;
                for (int i = 0; i < W; i++) begin
                    int idx;
                    idx = in_msb_first ? (W - 1 - i) : i;
                    expq.push_back({in_a[idx], in_b[idx], (i == 0), (i == W - 1)});
                end
            end
            prev_stall = ser_valid && !ser_ready;
            prev_out   = {ser_valid, ser_a, ser_b, ser_first, ser_last};
        end
    end

    // ---------------- ser_ready driver ----------------
    int         rmode = 2;      // 0: always ready, 1: pseudo-random stalls, 2: never ready
    logic [3:0] pat = 4'b1001;

    initial forever begin
        @(posedge clk);
        #1;
        if (rmode == 0)      ser_ready = 1'b1;
        else if (rmode == 1) ser_ready = pat[$urandom_range(0, 3)];
        else                 ser_ready = 1'b0;
    end

    // ---------------- helpers ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic msb);
        @(posedge clk);
        #1;
        in_a = a;
        in_b = b;
        in_msb_first = msb;
        in_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_xfers(input int n);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (rec.size() >= n) return;
        end
        chk("transfer_timeout", rec.size(), n);
    endtask

    // Stream bits as a vector, first transferred bit at the MSB end.
    function automatic logic [W-1:0] stream_vec(input int base, input int sel);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W; i++) v = {v[W-2:0], rec[base + i][sel]};
        return v;
    endfunction

    // Reverse of stream_vec: first transferred bit at bit 0 (LSB-first recovery).
    function automatic logic [W-1:0] lsb_word(input int base, input int sel);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W; i++) v[i] = rec[base + i][sel];
        return v;
    endfunction

    // MSB-first magnitude comparator: index at which A>B is decided, or -1.
    function automatic int gt_from(input int base);
        logic gt, lt;
        int   from;
        gt = 1'b0; lt = 1'b0; from = -1;
        for (int i = 0; i < W; i++) begin
            logic [3:0] r;
            r = rec[base + i];
            if (r[1]) begin gt = 1'b0; lt = 1'b0; end
            if (!gt && !lt) begin
                if (r[3] && !r[2]) begin gt = 1'b1; from = i; end
                else if (!r[3] && r[2]) lt = 1'b1;
            end
        end
        return gt ? from : -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        int base;
        logic [W-1:0] fv, lv;

        // Reset behaviour and in_ready rising on the first edge after release
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_in_reset", in_ready, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("in_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        chk("in_ready_first_edge", in_ready, 1);
        rmode = 0;
        @(posedge clk);
        #1;

        // MSB-first pair, with latency check
        base = rec.size();
        in_a = 16'h6482; in_b = 16'h6262; in_msb_first = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lat_edge_n_valid", ser_valid, 0);
        chk("lat_edge_n_busy", busy, 1);
        chk("lat_edge_n_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        chk("lat_edge_n1_valid", ser_valid, 1);
        chk("lat_edge_n1_first", ser_first, 1);
        wait_xfers(base + W);
        chk("msb_stream_a", stream_vec(base, 3), 16'b0110_0100_1000_0010);
        chk("msb_stream_b", stream_vec(base, 2), 16'b0110_0010_0110_0010);
        chk("msb_cmp_gt_from", gt_from(base), 5);

        // LSB-first pair
        base = rec.size();
        send(16'h6482, 16'h6262, 1'b0);
        wait_xfers(base + W);
        chk("lsb_stream_a", stream_vec(base, 3), 16'b0100_0001_0010_0110);
        chk("lsb_stream_b", stream_vec(base, 2), 16'b0100_0110_0100_0110);
        chk("lsb_word_a", lsb_word(base, 3), 16'h6482);
        fv = stream_vec(base, 1);
        lv = stream_vec(base, 0);
        chk("lsb_first_flags", fv, 16'h8000);
        chk("lsb_last_flags", lv, 16'h0001);

        // Three pairs back-to-back
        base = rec.size();
        fork
            begin
                send(16'h1234, 16'hABCD, 1'b1);
                send(16'h0F0F, 16'h00FF, 1'b0);
                send(16'h8001, 16'h7FFE, 1'b1);
            end
            begin
                int n;
                bit found;
                n = 0;
                found = 1'b0;
                while (!found && n < 100) begin
                    @(negedge clk);
                    if (ser_valid) found = 1'b1;
                    n++;
                end
                chk("b2b_start", found, 1);
                for (int k = 0; k < 3 * W; k++) begin
                    chk("b2b_valid", ser_valid, 1);
                    chk("b2b_first", ser_first, (k % W) == 0);
                    chk("b2b_last", ser_last, (k % W) == W - 1);
                    @(negedge clk);
                end
                chk("b2b_gap_after", ser_valid, 0);
            end
        join
        chk("b2b_w0_a", stream_vec(base, 3), 16'h1234);
        chk("b2b_w1_b", lsb_word(base + W, 2), 16'h00FF);
        chk("b2b_w2_b", stream_vec(base + 2 * W, 2), 16'h7FFE);

        // Pseudo-random stalls
        rmode = 1;
        base = rec.size();
        send(16'hFFFF, 16'h0001, 1'b1);
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_xfers(base + 2 * W);
        chk("stall_msb_a", stream_vec(base, 3), 16'hFFFF);
        chk("stall_msb_b", stream_vec(base, 2), 16'h0001);
        chk("stall_lsb_a", lsb_word(base + W, 3), 16'hFFFF);
        chk("stall_lsb_b", lsb_word(base + W, 2), 16'h0001);
        rmode = 0;
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-word with a second pair held
        base = rec.size();
        send(16'hC3A5, 16'h5A3C, 1'b1);
        send(16'h1111, 16'h2222, 1'b0);
        wait_xfers(base + 8);
        chk("pre_reset_slot_full", in_ready, 0);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_async_outputs", {in_ready, busy, ser_valid, ser_a, ser_b, ser_first, ser_last}, '0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_reset_quiet", {ser_valid, busy}, 0);
        end
        chk("no_bits_after_reset", rec.size(), base + 8);
        base = rec.size();
        send(16'h0BAD, 16'hF00D, 1'b1);
        wait_xfers(base + W);
        chk("post_reset_first", rec[base][1], 1);
        chk("post_reset_word_a", stream_vec(base, 3), 16'h0BAD);
        chk("post_reset_word_b", stream_vec(base, 2), 16'hF00D);

        repeat (4) @(posedge clk);
        chk("queue_drained", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
